// File: rtl/cpu_lsu_pkg.sv
// Shared types and constants for the CPU load/store unit.
//   lsu_size_t     : access size encoding carried on req_size
//   lsu_state_t    : sequencing states of the unit
//   LSU_ADDR_LIMIT : first byte address beyond the data memory
package cpu_lsu_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2,
        SIZE_X = 2'd3
    } lsu_size_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_t;

    localparam logic [31:0] LSU_ADDR_LIMIT = 32'd4096;

endpackage

// File: rtl/cpu_load_store_unit_if.sv
// Bus bundle between the CPU core, the load/store unit and the data memory.
//   req_*  : request channel, core -> unit (valid/ready)
//   resp_* : response channel, unit -> core (valid/ready)
//   mem_*  : word-wide memory port; mem_rd is combinational from mem_addr
// Modports:
//   master : the environment (core plus data memory)
//   slave  : the load/store unit
interface cpu_load_store_unit_if #(
    parameter int MEM_AW = 10,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [31:0]       req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_error;

    logic [MEM_AW-1:0] mem_addr;
    logic              mem_writeen;
    logic [DATA_W-1:0] mem_writeint;
    logic [DATA_W-1:0] mem_rd;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output resp_ready, mem_rd,
        input  req_ready, resp_valid, resp_rdata, resp_error,
        input  mem_addr, mem_writeen, mem_writeint
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  resp_ready, mem_rd,
        output req_ready, resp_valid, resp_rdata, resp_error,
        output mem_addr, mem_writeen, mem_writeint
    );
endinterface

// File: rtl/cpu_lsu_align.sv
// Combinational lane handling for the load/store unit.
//   chk_addr/chk_size -> chk_error  : range, alignment and size check of a request
//   size/lane/is_unsigned           : captured access shape, shared by both paths
//   rd_word -> load_data            : lane extract with sign/zero extension
//   old_word/wdata -> store_data    : read-modify-write merge of the store lanes
module cpu_lsu_align
    import cpu_lsu_pkg::*;
(
    input  logic [31:0] chk_addr,
    input  lsu_size_t   chk_size,
    output logic        chk_error,
    input  lsu_size_t   size,
    input  logic [1:0]  lane,
    input  logic        is_unsigned,
    input  logic [31:0] rd_word,
    output logic [31:0] load_data,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [31:0] store_data
);
    logic [4:0]  shift;
    logic [31:0] lane_mask;
    logic [31:0] shifted;

    always_comb begin
        shift = {lane, 3'b000};
        case (size)
            SIZE_B:  lane_mask = 32'h0000_00FF;
            SIZE_H:  lane_mask = 32'h0000_FFFF;
            SIZE_W:  lane_mask = 32'hFFFF_FFFF;
            default: lane_mask = 32'h0000_0000;
        endcase
    end

    always_comb begin
        shifted = rd_word >> shift;
        case (size)
            SIZE_B:  load_data = is_unsigned ? {24'd0, shifted[7:0]}
                                             : {{24{shifted[7]}}, shifted[7:0]};
            SIZE_H:  load_data = is_unsigned ? {16'd0, shifted[15:0]}
                                             : {{16{shifted[15]}}, shifted[15:0]};
            SIZE_W:  load_data = shifted;
            default: load_data = 32'd0;
        endcase
    end

    // For a word store the mask covers everything, so old_word drops out.
    assign store_data = (old_word & ~(lane_mask << shift)) | ((wdata & lane_mask) << shift);

    always_comb begin
        chk_error = 1'b0;
        if (chk_addr >= LSU_ADDR_LIMIT)
            chk_error = 1'b1;
        case (chk_size)
            SIZE_H:  if (chk_addr[0]) chk_error = 1'b1;
            SIZE_W:  if (chk_addr[1:0] != 2'b00) chk_error = 1'b1;
            SIZE_X:  chk_error = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: rtl/cpu_load_store_unit.sv
// Initiator side of the CPU data-memory port.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : slave view of cpu_load_store_unit_if (request, response, memory port)
// Accepts one request at a time, adds sub-word access by read-modify-write
// and reports misaligned, out-of-range or illegal-size requests as errors.
//
// state | meaning
// IDLE  | ready for a request; captures it on handshake
// READ  | memory read of the captured word (load, or first half of a sub-word store)
// WRITE | one-cycle memory write of the merged/whole word
// RESP  | response held until resp_ready
module cpu_load_store_unit
    import cpu_lsu_pkg::*;
#(
    parameter int MEM_AW = 10,
    parameter int DATA_W = 32
) (
    input logic                  clk,
    input logic                  reset,
    cpu_load_store_unit_if.slave bus
);
    lsu_state_t        state;
    lsu_state_t        next_state;

    logic              cap_write;
    lsu_size_t         cap_size;
    logic              cap_unsigned;
    logic [1:0]        cap_lane;
    logic [MEM_AW-1:0] cap_index;
    logic [DATA_W-1:0] cap_wdata;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] rdata_q;
    logic              error_q;

    logic              req_ready;
    logic              resp_valid;
    logic              mem_writeen;
    logic              chk_error;
    logic [31:0]       load_data;
    logic [31:0]       store_data;
    lsu_size_t         req_size;

    assign req_size = lsu_size_t'(bus.req_size);

    cpu_lsu_align u_align (
        .chk_addr    (bus.req_addr),
        .chk_size    (req_size),
        .chk_error   (chk_error),
        .size        (cap_size),
        .lane        (cap_lane),
        .is_unsigned (cap_unsigned),
        .rd_word     (bus.mem_rd),
        .load_data   (load_data),
        .old_word    (rd_word),
        .wdata       (cap_wdata),
        .store_data  (store_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state  = state;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        mem_writeen = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid) begin
                    if (chk_error)
                        next_state = RESP;
                    else if (bus.req_write && req_size == SIZE_W)
                        next_state = WRITE;
                    else
                        next_state = READ;
                end
            end
            READ:  next_state = cap_write ? WRITE : RESP;
            WRITE: begin
                mem_writeen = 1'b1;
                next_state  = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (bus.resp_ready)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_write    <= 1'b0;
            cap_size     <= SIZE_B;
            cap_unsigned <= 1'b0;
            cap_lane     <= 2'd0;
            cap_index    <= '0;
            cap_wdata    <= '0;
            rd_word      <= '0;
            rdata_q      <= '0;
            error_q      <= 1'b0;
        end else begin
            if (state == IDLE && bus.req_valid) begin
                cap_write    <= bus.req_write;
                cap_size     <= req_size;
                cap_unsigned <= bus.req_unsigned;
                cap_lane     <= bus.req_addr[1:0];
                cap_index    <= bus.req_addr[MEM_AW+1:2];
                cap_wdata    <= bus.req_wdata;
                // Stores and errors respond with zero data.
                rdata_q      <= '0;
                error_q      <= chk_error;
            end
            if (state == READ) begin
                rd_word <= bus.mem_rd;
                if (!cap_write)
                    rdata_q <= load_data;
            end
        end
    end

    assign bus.req_ready    = req_ready;
    assign bus.resp_valid   = resp_valid;
    assign bus.resp_rdata   = rdata_q;
    assign bus.resp_error   = error_q;
    assign bus.mem_addr     = cap_index;
    assign bus.mem_writeen  = mem_writeen;
    assign bus.mem_writeint = (state == WRITE) ? store_data : '0;
endmodule

// File: doc/cpu_load_store_unit.md
Name: cpu_load_store_unit

Overview:
- Initiator side of the CPU data-memory port. Takes load/store requests from the CPU core through a valid/ready handshake and drives the word-wide, 1024-entry data memory.
- The memory has a combinational read and a clocked write.
- Adds byte/halfword access, sign/zero extension, read-modify-write for sub-word stores, and alignment and range checks.
- Sits between the CPU execute stage and the data memory.

Parameters:
- MEM_AW, 10, word-address width of the data memory (1024 words).
- DATA_W, 32, data width. Fixed at 32; other values are unsupported.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_unsigned  input  1  loads only: zero-extend when 1, sign-extend when 0.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; the sub-word value is in the low bits.
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer accepts the response.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_error  output  1  request was misaligned, out of range, or illegal size.
- mem_addr  output  MEM_AW  memory word index.
- mem_writeen  output  1  memory write strobe.
- mem_writeint  output  32  memory write data.
- mem_rd  input  32  memory read data (combinational from mem_addr).

Behaviour:
- Reset values: all outputs and registers are 0; state = IDLE. req_ready is 1 after reset because it is decoded from IDLE.
- Byte lanes are little-endian. Word index = req_addr[11:2]; lane = req_addr[1:0].
- Error conditions:
  - addr[31:12] != 0
  - size = 3
  - half access with addr[0] = 1
  - word access with addr[1:0] != 0
- State machine, with 1-deep capture of the request:
  - IDLE: req_ready = 1. On req_valid & req_ready, capture the request and go to:
    - RESP, if the request is an error;
    - WRITE, for a word store;
    - READ, for a load or a sub-word store.
  - READ: mem_addr = captured index. Register mem_rd.
    - Load: extract the lane, sign- or zero-extend into resp_rdata, go to RESP.
    - Store: go to WRITE.
  - WRITE: mem_writeen = 1. mem_writeint = merge of the registered read word with the store lanes (a word store writes req_wdata unmodified). Next state is RESP.
  - RESP: resp_valid = 1, with resp_rdata and resp_error stable until resp_ready. Then go to IDLE.
- Timing:
  - No new request is accepted before returning to IDLE. req_ready is 0 in all other states.
  - Latency from the accept edge to the first resp_valid cycle: error 1, load 2, word store 2, sub-word store 3.
  - Minimum request spacing = latency + 1.
- mem_writeen is decoded from state alone, so it is asserted exactly one cycle per legal store and never for errors or loads.
- mem_addr holds the captured index outside IDLE; its value in IDLE is don't-care. It is cleared to 0 on reset.
- Reset in mid-operation:
  - Asynchronous return to IDLE; mem_writeen and resp_valid drop immediately.
  - A write whose clock edge coincides with asserted reset must not commit.
  - A pending response is discarded.
- Simultaneous resp_ready and new req_valid: the request is not accepted in the same cycle. It is accepted the cycle after returning to IDLE.

Decomposition:
- Package cpu_lsu_pkg holds:
  - lsu_size_t enum (SIZE_B, SIZE_H, SIZE_W, SIZE_X);
  - lsu_state_t enum (IDLE, READ, WRITE, RESP);
  - the constant LSU_ADDR_LIMIT = 4096.
- Sub-module cpu_lsu_align is purely combinational:
  - load path: lane extract + extend;
  - store path: lane merge;
  - error check.
  Both directions share the lane/size decode.

Test Plan:
Memory is preloaded with word0 = 49, word1 = 7, word2 = 2.
1. Load word, addr 0x004 -> resp_rdata = 0x00000007, resp_error = 0, resp_valid 2 cycles after accept, no mem_writeen.
2. Store byte 0xAB at 0x009 -> one mem_writeen cycle with mem_addr = 2 and mem_writeint = 0x0000AB02, response 3 cycles after accept. Then load signed byte 0x009 -> 0xFFFFFFAB, and load unsigned byte -> 0x000000AB.
3. Store half 0x1234 at 0x002, then load word 0x000 -> 0x12340031. Load half signed 0x002 -> 0x00001234.
4. Errors: half at 0x003, word at 0x006, size 3, word at 0x1000 -> each gives resp_error = 1 and resp_rdata = 0 one cycle after accept, with mem_writeen never asserted.
5. Backpressure: load 0x000 with resp_ready held low 4 cycles -> resp_valid stays 1 with rdata 49 (0x31) stable, and req_ready = 0. A req_valid held high is accepted only the cycle after the handshake.
6. Reset asserted during WRITE of a word store to 0x008 (value 0xDEADBEEF) -> mem_writeen drops immediately, word2 remains 0x00000002, and state is IDLE with req_ready = 1 after reset release.
